// File: rtl/a25_wishbone_wbuf.sv
// Posted-write buffer between one Amber core port and the wishbone arbiter.
// Writes are queued in a circular FIFO; reads wait for the FIFO to drain and have one read in flight.
module a25_wishbone_wbuf #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req,
  input  logic                      i_write,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_be,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      o_ready,
  output logic                      o_valid,
  input  logic                      i_accepted,
  output logic                      o_write,
  output logic [DATA_WIDTH-1:0]     o_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_be,
  output logic [ADDR_WIDTH-1:0]     o_addr,
  input  logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic                      i_rdata_valid,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t                state_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;

  logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];
  logic [BW-1:0]         be_mem    [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];

  logic fifo_nonempty;
  logic in_idle;
  logic pop;
  logic bypass;
  logic space;
  logic push;
  logic rd_done;

  assign fifo_nonempty = (count_reg != '0);
  assign in_idle       = (state_reg == IDLE);

  // The buffer always has priority on the bus so writes leave in issue order
  // and a read can only be presented once every buffered write has gone.
  assign o_valid = (fifo_nonempty | i_req) & in_idle & i_rst_n;
  assign o_write = fifo_nonempty ? 1'b1 : i_write;
  assign o_wdata = fifo_nonempty ? wdata_mem[rd_ptr_reg] : i_wdata;
  assign o_addr  = fifo_nonempty ? addr_mem[rd_ptr_reg] : i_addr;
  assign o_be    = fifo_nonempty ? be_mem[rd_ptr_reg] : (i_write ? i_be : {BW{1'b1}});

  assign pop     = fifo_nonempty & o_valid & i_accepted;
  assign bypass  = ~fifo_nonempty & o_valid & i_accepted;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign space   = (count_reg != CW'(DEPTH)) | pop;
  assign push    = i_rst_n & i_req & i_write & ~bypass & space;
  assign rd_done = i_rst_n & (state_reg == RD_WAIT) & i_rdata_valid;

  assign o_ready    = (i_req & i_write & (bypass | push)) | rd_done;
  assign o_rdata    = i_rdata;
  assign o_count    = count_reg;
  assign o_empty    = (count_reg == '0) & in_idle;
  assign count_next = count_reg + CW'(push) - CW'(pop);

  // Entry storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      wdata_mem[wr_ptr_reg] <= i_wdata;
      be_mem[wr_ptr_reg]    <= i_be;
      addr_mem[wr_ptr_reg]  <= i_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
      unique case (state_reg)
        IDLE: begin
          if (o_valid & ~o_write & i_accepted) begin
            state_reg <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (i_rdata_valid) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a25_wishbone_wbuf.sv
// Randomised and directed bench for a25_wishbone_wbuf: a queue of expected bus
// transactions in core issue order is checked by a negedge monitor.
module tb_a25_wishbone_wbuf;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int BW    = DW / 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] FIX_DATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_req;
  logic          i_write;
  logic [DW-1:0] i_wdata;
  logic [BW-1:0] i_be;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] o_rdata;
  logic          o_ready;
  logic          o_valid;
  logic          i_accepted;
  logic          o_write;
  logic [DW-1:0] o_wdata;
  logic [BW-1:0] o_be;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] i_rdata;
  logic          i_rdata_valid;
  logic [CW-1:0] o_count;
  logic          o_empty;

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } bus_t;

  bus_t          exp_bus[$];
  int            total = 0;
  int            bad = 0;
  int            acc_mode = 0;
  int            rd_lat_cfg = 1;
  int            rsp_wait = 0;
  int            acked_w = 0;
  int            bus_w = 0;
  bit            rsp_armed = 1'b0;
  bit            spur_req = 1'b0;
  bit            rd_outstanding = 1'b0;
  bit            rd_fix = 1'b0;
  logic [DW-1:0] exp_rdata = '0;

  a25_wishbone_wbuf #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_req(i_req),
    .i_write(i_write),
    .i_wdata(i_wdata),
    .i_be(i_be),
    .i_addr(i_addr),
    .o_rdata(o_rdata),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .i_accepted(i_accepted),
    .o_write(o_write),
    .o_wdata(o_wdata),
    .o_be(o_be),
    .o_addr(o_addr),
    .i_rdata(i_rdata),
    .i_rdata_valid(i_rdata_valid),
    .o_count(o_count),
    .o_empty(o_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name, input int limit);
    total++;
    bad++;
    $display("FAIL %s: event did not occur within %0d cycles, expected it to (t=%0t)", name, limit, $time);
  endtask

  // Arbiter acceptance, applied 2 time units after each rising edge.
  initial begin
    i_accepted = 1'b0;
    forever begin
      @(posedge i_clk);
      #2;
      case (acc_mode)
        0:       i_accepted = 1'b0;
        1:       i_accepted = 1'b1;
        default: i_accepted = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Bus read responder: returns data a programmed number of cycles after acceptance.
  initial begin
    i_rdata_valid = 1'b0;
    i_rdata = '0;
    forever begin
      @(posedge i_clk);
      #2;
      i_rdata_valid = 1'b0;
      if (spur_req) begin
        i_rdata_valid = 1'b1;
        i_rdata = {$urandom, $urandom, $urandom, $urandom};
        spur_req = 1'b0;
      end else if (rsp_armed) begin
        if (rsp_wait <= 1) begin
          i_rdata_valid = 1'b1;
          i_rdata = rd_fix ? FIX_DATA : {$urandom, $urandom, $urandom, $urandom};
          exp_rdata = i_rdata;
          rsp_armed = 1'b0;
        end else begin
          rsp_wait--;
        end
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge i_clk) begin
    bus_t e;
    if (!i_rst_n) begin
      chk("rst_valid", DW'(o_valid), DW'(0));
      chk("rst_ready", DW'(o_ready), DW'(0));
      chk("rst_count", DW'(o_count), DW'(0));
      chk("rst_empty", DW'(o_empty), DW'(1));
    end else begin
      chk("count", DW'(o_count), DW'(acked_w - bus_w));
      chk("empty", DW'(o_empty), DW'(acked_w == bus_w && !rd_outstanding));
      if (rd_outstanding) chk("valid_in_rdwait", DW'(o_valid), DW'(0));
      if (i_rdata_valid) begin
        if (rd_outstanding) begin
          chk("read_ready", DW'(o_ready), DW'(1));
          chk("read_data", o_rdata, exp_rdata);
          $display("read done data=%h", o_rdata);
          rd_outstanding = 1'b0;
        end else if (!(i_req && i_write)) begin
          chk("spurious_ready", DW'(o_ready), DW'(0));
        end
      end
      if (o_valid && i_accepted) begin
        if (exp_bus.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_unexpected: got addr %0h, expected no transaction", o_addr);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_write", DW'(o_write), DW'(e.w));
          chk("bus_addr", DW'(o_addr), DW'(e.a));
          chk("bus_be", DW'(o_be), DW'(e.be));
          if (e.w) chk("bus_wdata", o_wdata, e.d);
          $display("bus txn %s addr=%h be=%h", o_write ? "WR" : "RD", o_addr, o_be);
        end
        if (!o_write) begin
          rd_outstanding = 1'b1;
          rsp_wait = (rd_lat_cfg == 0) ? int'($urandom_range(1, 4)) : rd_lat_cfg;
          rsp_armed = 1'b1;
        end
      end
      if (o_ready && i_req && i_write) acked_w++;
      if (o_valid && i_accepted && o_write) bus_w++;
    end
  end

  task automatic start_req(input logic w, input logic [AW-1:0] a);
    bus_t e;
    i_req   = 1'b1;
    i_write = w;
    i_addr  = a;
    i_wdata = {$urandom, $urandom, $urandom, $urandom};
    i_be    = BW'($urandom);
    e.w  = w;
    e.a  = a;
    e.d  = i_wdata;
    e.be = w ? i_be : {BW{1'b1}};
    exp_bus.push_back(e);
  endtask

  // Called 1 unit after a rising edge; returns at the same phase, one edge after o_ready.
  task automatic issue(input logic w, input logic [AW-1:0] a, output int cyc);
    start_req(w, a);
    cyc = 0;
    while (1) begin
      @(negedge i_clk);
      cyc++;
      if (o_ready) break;
      if (cyc >= 60) begin
        timeout("ready_wait", 60);
        break;
      end
      @(posedge i_clk);
      #1;
    end
    @(posedge i_clk);
    #1;
    i_req = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int limit);
    int n;
    n = 0;
    while (1) begin
      @(negedge i_clk);
      if (o_empty) break;
      n++;
      if (n >= limit) begin
        timeout(name, limit);
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_read_accept(input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge i_clk);
      if (o_valid && i_accepted && !o_write) break;
      n++;
      if (n >= 20) begin
        timeout(name, 20);
        break;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic w;
    i_rst_n = 1'b1;
    i_req   = 1'b0;
    i_write = 1'b0;
    i_addr  = '0;
    i_wdata = '0;
    i_be    = '0;
    #1 i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // Bypass: three back-to-back writes with the arbiter always accepting.
    acc_mode = 1;
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 32'h100 + 32'(i * 16), cyc);
      chk("bypass_ready_cycles", DW'(cyc), DW'(1));
    end
    @(negedge i_clk);
    chk("bypass_count", DW'(o_count), DW'(0));
    @(posedge i_clk);
    #1;

    // Fill to full, fifth write held, then pushed alongside a pop.
    acc_mode = 0;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h130 + 32'(i * 16), cyc);
      chk("fill_ready_cycles", DW'(cyc), DW'(1));
    end
    start_req(1'b1, 32'h170);
    @(negedge i_clk);
    chk("full_hold", DW'(o_ready), DW'(0));
    chk("full_count", DW'(o_count), DW'(4));
    @(posedge i_clk);
    #1 acc_mode = 1;
    @(negedge i_clk);
    chk("full_push", DW'(o_ready), DW'(1));
    @(posedge i_clk);
    #1 i_req = 1'b0;
    @(negedge i_clk);
    chk("count_after_full_push", DW'(o_count), DW'(4));
    @(posedge i_clk);
    #1;

    // Drain across the pointer wrap while issuing more writes.
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 32'h180 + 32'(i * 16), cyc);
      chk("wrap_ready_cycles", DW'(cyc), DW'(1));
    end
    wait_empty("drain", 20);
    chk("drain_count", DW'(o_count), DW'(0));

    // Read queued behind two buffered writes, data returned 3 cycles after acceptance.
    acc_mode = 0;
    issue(1'b1, 32'h1C0, cyc);
    issue(1'b1, 32'h1D0, cyc);
    acc_mode = 1;
    rd_lat_cfg = 3;
    rd_fix = 1'b1;
    issue(1'b0, 32'h200, cyc);
    chk("read_latency", DW'(cyc), DW'(6));
    rd_fix = 1'b0;

    // Read data pulse while idle must not complete anything.
    spur_req = 1'b1;
    @(negedge i_clk);
    chk("spurious_direct", DW'(o_ready), DW'(0));
    chk("spurious_empty", DW'(o_empty), DW'(1));
    @(posedge i_clk);
    #1;

    // Write pushed while a read is outstanding stays buffered until read data returns.
    rd_lat_cfg = 4;
    start_req(1'b0, 32'h300);
    wait_read_accept("held_read_accept");
    start_req(1'b1, 32'h310);
    @(negedge i_clk);
    chk("rdwait_push_ready", DW'(o_ready), DW'(1));
    chk("rdwait_valid", DW'(o_valid), DW'(0));
    @(posedge i_clk);
    #1 i_req = 1'b0;
    @(negedge i_clk);
    chk("rdwait_count", DW'(o_count), DW'(1));
    chk("rdwait_valid2", DW'(o_valid), DW'(0));
    @(posedge i_clk);
    #1;
    wait_empty("held_drain", 20);

    // Asynchronous reset with a read outstanding and three writes buffered.
    rd_lat_cfg = 20;
    start_req(1'b0, 32'h400);
    wait_read_accept("reset_read_accept");
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 32'h410 + 32'(i * 16), cyc);
    end
    start_req(1'b1, 32'h500);
    #1;
    chk("pre_reset_count", DW'(o_count), DW'(3));
    i_rst_n = 1'b0;
    #1;
    chk("async_rst_valid", DW'(o_valid), DW'(0));
    chk("async_rst_ready", DW'(o_ready), DW'(0));
    chk("async_rst_count", DW'(o_count), DW'(0));
    chk("async_rst_empty", DW'(o_empty), DW'(1));
    exp_bus.delete();
    acked_w = 0;
    bus_w = 0;
    rd_outstanding = 1'b0;
    i_req = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (25) @(posedge i_clk);
    #1;
    chk("post_reset_empty", DW'(o_empty), DW'(1));

    // Randomised mix of reads and writes against random acceptance.
    acc_mode = 2;
    rd_lat_cfg = 0;
    for (int i = 0; i < 80; i++) begin
      w = ($urandom_range(0, 3) != 0);
      issue(w, $urandom & 32'hFFFF_FFF0, cyc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge i_clk);
        #1;
      end
    end
    acc_mode = 1;
    wait_empty("final_drain", 40);
    chk("final_sb_empty", DW'(exp_bus.size()), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
